// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - SHA-256 block controller: message load, IV/var init, 64 rounds, hash update
`timescale 1ns/1ps
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = 64,
    parameter int NUM_WORDS  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       first_block,
    input  logic       abort,
    input  logic       msg_valid,
    output logic       msg_ready,
    output logic       w_load,
    output logic       h_init,
    output logic       vars_init,
    output logic       round_en,
    output logic       w_expand,
    output logic [6:0] k_idx,
    output logic       hash_update,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        INIT   = 3'd2,
        ROUND  = 3'd3,
        UPDATE = 3'd4
    } state_t;

    localparam logic [3:0] LAST_WORD    = 4'(NUM_WORDS - 1);
    localparam logic [5:0] LAST_ROUND   = 6'(NUM_ROUNDS - 1);
    localparam logic [5:0] EXPAND_START = 6'(NUM_WORDS);

    state_t     state_q, state_d;
    logic [3:0] word_cnt_q, word_cnt_d;
    logic [5:0] round_cnt_q, round_cnt_d;
    logic       msg_ready_q, msg_ready_d;
    logic       h_init_q, h_init_d;
    logic       vars_init_q, vars_init_d;
    logic       round_en_q, round_en_d;
    logic       w_expand_q, w_expand_d;
    logic [6:0] k_idx_q, k_idx_d;
    logic       update_q, update_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        round_cnt_d = round_cnt_q;
        h_init_d    = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            word_cnt_d  = '0;
            round_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = LOAD;
                        word_cnt_d  = '0;
                        round_cnt_d = '0;
                        h_init_d    = first_block;
                    end
                end
                LOAD: begin
                    // msg_ready is high throughout LOAD, so msg_valid alone marks an accept
                    if (msg_valid) begin
                        word_cnt_d = word_cnt_q + 4'd1;
                        if (word_cnt_q == LAST_WORD) begin
                            state_d = INIT;
                        end
                    end
                end
                INIT: begin
                    state_d     = ROUND;
                    round_cnt_d = '0;
                end
                ROUND: begin
                    if (round_cnt_q == LAST_ROUND) begin
                        state_d = UPDATE;
                    end else begin
                        round_cnt_d = round_cnt_q + 6'd1;
                    end
                end
                UPDATE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they leave flops aligned with the state
        msg_ready_d = (state_d == LOAD);
        vars_init_d = (state_d == INIT);
        round_en_d  = (state_d == ROUND);
        w_expand_d  = (state_d == ROUND) && (round_cnt_d >= EXPAND_START);
        k_idx_d     = (state_d == ROUND) ? {1'b0, round_cnt_d} : 7'd0;
        update_d    = (state_d == UPDATE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            round_cnt_q <= '0;
            msg_ready_q <= 1'b0;
            h_init_q    <= 1'b0;
            vars_init_q <= 1'b0;
            round_en_q  <= 1'b0;
            w_expand_q  <= 1'b0;
            k_idx_q     <= '0;
            update_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            round_cnt_q <= round_cnt_d;
            msg_ready_q <= msg_ready_d;
            h_init_q    <= h_init_d;
            vars_init_q <= vars_init_d;
            round_en_q  <= round_en_d;
            w_expand_q  <= w_expand_d;
            k_idx_q     <= k_idx_d;
            update_q    <= update_d;
            busy_q      <= busy_d;
        end
    end

    assign msg_ready   = msg_ready_q;
    assign w_load      = msg_valid & msg_ready_q;
    assign h_init      = h_init_q;
    assign vars_init   = vars_init_q;
    assign round_en    = round_en_q;
    assign w_expand    = w_expand_q;
    assign k_idx       = k_idx_q;
    assign hash_update = update_q;
    assign done        = update_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb/tb_sha256_round_ctrl.sv - self-checking bench for sha256_round_ctrl
`timescale 1ns/1ps
module tb_sha256_round_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       first_block;
    logic       abort;
    logic       msg_valid;
    logic       msg_ready;
    logic       w_load;
    logic       h_init;
    logic       vars_init;
    logic       round_en;
    logic       w_expand;
    logic [6:0] k_idx;
    logic       hash_update;
    logic       busy;
    logic       done;

    sha256_round_ctrl #(.NUM_ROUNDS(64), .NUM_WORDS(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .first_block(first_block),
        .abort(abort), .msg_valid(msg_valid), .msg_ready(msg_ready), .w_load(w_load),
        .h_init(h_init), .vars_init(vars_init), .round_en(round_en), .w_expand(w_expand),
        .k_idx(k_idx), .hash_update(hash_update), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Block model: step 0..15 waiting for word n, 16 init, 17..80 round (step-17), 81 update
    int cyc = 0;
    always @(posedge clk) cyc++;

    bit m_active;
    bit m_fresh;
    bit m_first;
    int m_step;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_fresh = 0; m_step = 0;
        end else if (abort) begin
            m_active = 0; m_fresh = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_step = 0; m_first = first_block; m_fresh = 1;
            end
        end else begin
            m_fresh = 0;
            if (m_step < 16) begin
                if (msg_valid) m_step++;
            end else if (m_step == 81) begin
                m_active = 0;
            end else begin
                m_step++;
            end
        end
    end

    always @(negedge clk) begin
        bit e_ready, e_round, e_upd;
        int e_k;
        e_ready = m_active && m_step < 16;
        e_round = m_active && m_step >= 17 && m_step <= 80;
        e_upd   = m_active && m_step == 81;
        e_k     = e_round ? m_step - 17 : 0;
        chk("msg_ready",   32'(msg_ready),   32'(e_ready));
        chk("w_load",      32'(w_load),      32'(e_ready && msg_valid));
        chk("h_init",      32'(h_init),      32'(m_active && m_fresh && m_first));
        chk("vars_init",   32'(vars_init),   32'(m_active && m_step == 16));
        chk("round_en",    32'(round_en),    32'(e_round));
        chk("k_idx",       32'(k_idx),       32'(e_k));
        chk("w_expand",    32'(w_expand),    32'(e_round && e_k >= 16));
        chk("hash_update", 32'(hash_update), 32'(e_upd));
        chk("done",        32'(done),        32'(e_upd));
        chk("busy",        32'(busy),        32'(m_active));
        chk("one_hot_ctrl", 32'(int'(h_init) + int'(vars_init) + int'(round_en) + int'(hash_update) <= 1), 32'd1);
        chk("k_idx_range", 32'(k_idx <= 7'd63), 32'd1);
        chk("wload_ready", 32'(!w_load || msg_ready), 32'd1);
    end

    // Event recorder, cycle numbers relative to the cycle in which start was driven
    int base = 0;
    int h_cnt, h_at, wl_cnt, wl_first, wl_last, vars_at, wexp_at;
    int done_cnt, done_at, done2_at, hu_cnt, k18, k81;

    task automatic clear_mon();
        h_cnt = 0; h_at = -1; wl_cnt = 0; wl_first = -1; wl_last = -1; vars_at = -1;
        wexp_at = -1; done_cnt = 0; done_at = -1; done2_at = -1; hu_cnt = 0; k18 = -1; k81 = -1;
    endtask

    always @(negedge clk) begin
        int rel;
        rel = cyc - base;
        if (rst_n) begin
            if (h_init) begin h_cnt++; h_at = rel; end
            if (w_load) begin
                wl_cnt++;
                if (wl_first < 0) wl_first = rel;
                wl_last = rel;
            end
            if (vars_init) vars_at = rel;
            if (w_expand && wexp_at < 0) wexp_at = rel;
            if (hash_update) hu_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_at = rel; else done2_at = rel;
            end
            if (rel == 18) k18 = int'(k_idx);
            if (rel == 81) k81 = int'(k_idx);
        end
    end

    task automatic wait_rel(input int n);
        while (cyc - base < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int n, input int limit);
        while (done_cnt < n && cyc - base < limit) begin
            @(posedge clk);
            #1;
        end
        chk("done_within_budget", 32'(done_cnt >= n), 32'd1);
    endtask

    task automatic launch(input logic fb);
        @(posedge clk);
        #1;
        clear_mon();
        first_block = fb;
        start = 1'b1;
        base = cyc;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; first_block = 1'b0; abort = 1'b0; msg_valid = 1'b0;
        clear_mon();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_k_idx", 32'(k_idx), 32'd0);
        chk("rst_msg_ready", 32'(msg_ready), 32'd0);
        rst_n = 1'b1;

        // Nominal block, msg_valid held high
        msg_valid = 1'b1;
        launch(1'b1);
        wait_rel(1);
        start = 1'b0;
        wait_done(1, 200);
        chk("t1_h_init_count", 32'(h_cnt), 32'd1);
        chk("t1_h_init_cycle", 32'(h_at), 32'd1);
        chk("t1_wload_count", 32'(wl_cnt), 32'd16);
        chk("t1_wload_first", 32'(wl_first), 32'd1);
        chk("t1_wload_last", 32'(wl_last), 32'd16);
        chk("t1_vars_cycle", 32'(vars_at), 32'd17);
        chk("t1_k_at_18", 32'(k18), 32'd0);
        chk("t1_k_at_81", 32'(k81), 32'd63);
        chk("t1_wexp_first", 32'(wexp_at), 32'd34);
        chk("t1_done_cycle", 32'(done_at), 32'd82);
        chk("t1_hash_update_count", 32'(hu_cnt), 32'd1);
        wait_rel(84);

        // Three stall cycles after word 5
        launch(1'b1);
        wait_rel(1);
        start = 1'b0;
        wait_rel(7);
        msg_valid = 1'b0;
        wait_rel(10);
        msg_valid = 1'b1;
        wait_done(1, 200);
        chk("t2_wload_count", 32'(wl_cnt), 32'd16);
        chk("t2_vars_cycle", 32'(vars_at), 32'd20);
        chk("t2_done_cycle", 32'(done_at), 32'd85);
        wait_rel(87);

        // Abort at k_idx 40, then a non-first block
        launch(1'b1);
        wait_rel(1);
        start = 1'b0;
        wait_rel(58);
        chk("t3_k_before_abort", 32'(k_idx), 32'd40);
        abort = 1'b1;
        wait_rel(59);
        abort = 1'b0;
        chk("t3_busy_after_abort", 32'(busy), 32'd0);
        chk("t3_k_after_abort", 32'(k_idx), 32'd0);
        wait_rel(62);
        chk("t3_no_done", 32'(done_cnt), 32'd0);
        chk("t3_no_hash_update", 32'(hu_cnt), 32'd0);
        launch(1'b0);
        wait_rel(1);
        start = 1'b0;
        wait_done(1, 200);
        chk("t3b_done_cycle", 32'(done_at), 32'd82);
        chk("t3b_h_init_count", 32'(h_cnt), 32'd0);
        chk("t3b_wload_count", 32'(wl_cnt), 32'd16);
        wait_rel(84);

        // Asynchronous reset mid-LOAD at word_cnt 7
        launch(1'b1);
        wait_rel(1);
        start = 1'b0;
        wait_rel(8);
        chk("t4_words_before_reset", 32'(wl_cnt), 32'd7);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_msg_ready", 32'(msg_ready), 32'd0);
        chk("t4_rst_w_load", 32'(w_load), 32'd0);
        chk("t4_rst_busy", 32'(busy), 32'd0);
        chk("t4_rst_k_idx", 32'(k_idx), 32'd0);
        chk("t4_rst_h_init", 32'(h_init), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_busy_after_release", 32'(busy), 32'd0);
        chk("t4_no_done", 32'(done_cnt), 32'd0);

        // start held high: back-to-back blocks
        launch(1'b1);
        wait_rel(1);
        chk("t5_first_edge_accept", 32'(msg_ready), 32'd1);
        chk("t5_h_init_first", 32'(h_init), 32'd1);
        wait_rel(83);
        chk("t5_idle_gap_busy", 32'(busy), 32'd0);
        wait_rel(84);
        chk("t5_second_accept", 32'(h_init), 32'd1);
        wait_done(2, 300);
        start = 1'b0;
        chk("t5_done1_cycle", 32'(done_at), 32'd82);
        chk("t5_done2_cycle", 32'(done2_at), 32'd165);
        chk("t5_wload_count", 32'(wl_cnt), 32'd32);
        chk("t5_hash_update_count", 32'(hu_cnt), 32'd2);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_idle_at_end", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
